// File: rtl/slope_conv_ctrl_pkg.sv
// Shared definitions for the single-slope conversion controller:
// FSM state encodings and default sizing.
`default_nettype none

package slope_conv_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RAMP   = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam int CNT_W_DEF      = 8;
   localparam int SETTLE_CYC_DEF = 4;
   localparam int LAT_COMP_DEF   = 3;

endpackage

`default_nettype wire

// File: rtl/sat_up_counter.sv
// Up-counter with synchronous clear and an at-max flag; holds at full scale
// instead of wrapping.
`default_nettype none

module sat_up_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             at_max_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !at_max_o) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o    = cnt_q;
   assign at_max_o = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/slope_conv_ctrl.sv
// Single-slope conversion controller: settles and runs the ramp, captures the
// latency-corrected count on comp_pulse and offers it on a valid/ready port.
`default_nettype none

module slope_conv_ctrl
   import slope_conv_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int LAT_COMP   = LAT_COMP_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             comp_pulse_i,
   output logic             ramp_rst_o,
   output logic             ramp_en_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] result_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic             overflow_o
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] LAT        = CNT_W'(LAT_COMP);

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             ramp_rst_q, ramp_en_q, busy_q;

   logic             cnt_clr, cnt_en, cnt_at_max;
   logic [CNT_W-1:0] cnt;

   sat_up_counter #(
      .WIDTH (CNT_W)
   ) u_ramp_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .cnt_o    (cnt),
      .at_max_o (cnt_at_max)
   );

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      result_d = result_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_RAMP;
               cnt_clr = 1'b1;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         ST_RAMP: begin
            // A trip on the full-scale cycle is a real reading, not an overflow.
            if (comp_pulse_i) begin
               result_d = (cnt >= LAT) ? (cnt - LAT) : '0;
               ovf_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = ST_HOLD;
            end else if (cnt_at_max) begin
               result_d = '1;
               ovf_d    = 1'b1;
               valid_d  = 1'b1;
               state_d  = ST_HOLD;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_HOLD: begin
            if (result_ready_i) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         ramp_rst_q <= 1'b1;
         ramp_en_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         ramp_rst_q <= (state_d != ST_RAMP);
         ramp_en_q  <= (state_d == ST_RAMP);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign ramp_rst_o     = ramp_rst_q;
   assign ramp_en_o      = ramp_en_q;
   assign busy_o         = busy_q;
   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign overflow_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_slope_conv_ctrl.sv
// Directed bench for slope_conv_ctrl (CNT_W=8, SETTLE_CYC=4, LAT_COMP=3);
// outputs are sampled 1 ns after each rising edge.
`default_nettype none

module tb_slope_conv_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       comp = 1'b0;
   logic       ready = 1'b0;
   logic       ramp_rst, ramp_en, busy, valid, ovf;
   logic [7:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   slope_conv_ctrl #(
      .CNT_W      (8),
      .SETTLE_CYC (4),
      .LAT_COMP   (3)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .comp_pulse_i   (comp),
      .ramp_rst_o     (ramp_rst),
      .ramp_en_o      (ramp_en),
      .busy_o         (busy),
      .result_o       (result),
      .result_valid_o (valid),
      .result_ready_i (ready),
      .overflow_o     (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse start, then wait out the four settle cycles; on return cnt=0 in RAMP.
   task automatic to_ramp();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(4);
   endtask

   task automatic accept();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   initial begin
      // 1: reset values
      tick(2);
      check("rst ramp_rst", ramp_rst, 1);
      check("rst ramp_en", ramp_en, 0);
      check("rst busy", busy, 0);
      check("rst result", result, 0);
      check("rst valid", valid, 0);
      check("rst ovf", ovf, 0);
      rst_n = 1'b1;
      tick(2);

      // 2: settle timing, trip at cnt=40, back-pressure
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2 busy", busy, 1);
      check("t2 settle ramp_rst", ramp_rst, 1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t2 settle ramp_en", ramp_en, 0);
      end
      tick();
      check("t2 ramp_en", ramp_en, 1);
      check("t2 ramp_rst", ramp_rst, 0);
      tick(40);
      check("t2 no valid in ramp", valid, 0);
      comp = 1'b1;
      tick();
      comp = 1'b0;
      check("t2 result", result, 37);
      check("t2 ovf", ovf, 0);
      check("t2 valid", valid, 1);
      check("t2 hold ramp_en", ramp_en, 0);
      check("t2 hold ramp_rst", ramp_rst, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2 stall valid", valid, 1);
         check("t2 stall result", result, 37);
      end
      accept();
      check("t2 accepted valid", valid, 0);
      check("t2 idle busy", busy, 0);
      check("t2 kept result", result, 37);

      // 3: trip below latency saturates to 0; ready raised before valid
      to_ramp();
      ready = 1'b1;
      tick(1);
      comp = 1'b1;
      tick();
      comp = 1'b0;
      check("t3 result", result, 0);
      check("t3 ovf", ovf, 0);
      check("t3 valid", valid, 1);
      tick();
      ready = 1'b0;
      check("t3 early ready accept", valid, 0);
      check("t3 idle busy", busy, 0);

      // 4: no trip -> full-scale overflow after 256 ramp cycles
      to_ramp();
      tick(255);
      check("t4 still ramping", ramp_en, 1);
      check("t4 no valid yet", valid, 0);
      tick();
      check("t4 result", result, 255);
      check("t4 ovf", ovf, 1);
      check("t4 ramp_en", ramp_en, 0);
      check("t4 valid", valid, 1);
      accept();
      check("t4 kept ovf", ovf, 1);

      // 5: trip on the full-scale cycle; stray start/comp ignored
      to_ramp();
      tick(255);
      comp = 1'b1;
      start = 1'b1;
      tick();
      check("t5 result", result, 252);
      check("t5 ovf", ovf, 0);
      check("t5 valid", valid, 1);
      tick();
      comp = 1'b0;
      start = 1'b0;
      check("t5 hold valid", valid, 1);
      check("t5 hold result", result, 252);
      check("t5 hold busy", busy, 1);
      ready = 1'b1;
      start = 1'b1;
      tick();
      ready = 1'b0;
      start = 1'b0;
      check("t5 accept valid", valid, 0);
      check("t5 accept busy", busy, 0);
      tick();
      check("t5 start not queued", busy, 0);
      comp = 1'b1;
      tick();
      comp = 1'b0;
      check("t5 idle comp busy", busy, 0);
      check("t5 idle comp valid", valid, 0);
      check("t5 idle comp result", result, 252);

      // 6: async reset mid-ramp, then a clean conversion
      to_ramp();
      tick(20);
      rst_n = 1'b0;
      #1;
      check("t6 rst ramp_en", ramp_en, 0);
      check("t6 rst ramp_rst", ramp_rst, 1);
      check("t6 rst busy", busy, 0);
      check("t6 rst result", result, 0);
      check("t6 rst ovf", ovf, 0);
      tick(3);
      check("t6 rst valid", valid, 0);
      rst_n = 1'b1;
      tick(2);
      check("t6 post rst valid", valid, 0);
      check("t6 post rst busy", busy, 0);
      to_ramp();
      tick(10);
      comp = 1'b1;
      tick();
      comp = 1'b0;
      check("t6 result", result, 7);
      check("t6 valid", valid, 1);
      accept();
      check("t6 done", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
